c3lib_sync_filt_bitsync: RTL
============================

// Module: c3lib_sync_filt_bitsync
// PURPOSE
//  Parametrised multi-bit CDC bit synchronizer: configurable stage count, per-bit
//  reset value, and optional per-bit stability (deglitch) filter after the sync
//  chain. Used for quasi-static control/status bits crossing into the clk domain
//  where metastability protection and glitch rejection are both required.
// PARAMETERS
//  DWIDTH       1  number of independent bits synchronized
//  SYNC_STAGES  2  flops in sync chain; legal 2..4, elaboration error otherwise
//  RESET_VAL    0  [DWIDTH-1:0] vector; bit i = reset value of every flop of bit i
//  FILTER_CNT   0  0 = filter bypassed; F>=1 = bit must differ F consecutive cycles
//  CNT_W        localparam = max(1,$clog2(FILTER_CNT+1)); filter counter width
// PORTS
//  clk          in   1       destination-domain clock
//  rst_n        in   1       async active-low reset; deassertion synchronous to clk
//  data_in      in   DWIDTH  asynchronous input bits
//  data_out     out  DWIDTH  synchronized (and filtered) bits
//  rise_pulse   out  DWIDTH  1-cycle pulse when data_out[i] goes 0->1 (optional)
//  fall_pulse   out  DWIDTH  1-cycle pulse when data_out[i] goes 1->0 (optional)
// BEHAVIOUR
//  - Reset (async assert): all sync flops, data_out, and edge-history flops of bit
//    i = RESET_VAL[i]; filter counters = 0; rise/fall_pulse = 0. Takes effect
//    immediately, mid-operation included; in-flight values discarded.
//  - Sync chain: s[k] <= s[k-1], s[0] <= data_in; sync value S = s[SYNC_STAGES-1].
//  - FILTER_CNT==0: data_out = S directly (no extra flop); latency SYNC_STAGES
//    clk edges from first sampling edge.
//  - FILTER_CNT==F>=1, per bit i, registered data_out[i], counter cnt[i]:
//      S[i]==data_out[i]            -> cnt[i] <= 0
//      S[i]!=data_out[i], cnt<F-1   -> cnt[i] <= cnt[i]+1
//      S[i]!=data_out[i], cnt==F-1  -> data_out[i] <= S[i]; cnt[i] <= 0
//    Latency for a stable change: SYNC_STAGES+F edges. Any S excursion shorter
//    than F cycles is rejected and the counter restarts from 0. Counter never
//    exceeds F-1, so no wrap. F=1 = plain extra retiming flop.
//  - Bits are fully independent; no cross-bit coherency guaranteed (not for
//    multi-bit buses that need atomic transfer; use a handshake/gray sync instead).
//  - data_in toggling every cycle: with F>=2 data_out holds its value indefinitely.
// CONFIGURATION
//  - Macro C3LIB_SYNC_EDGE_DET_EN:
//    defined   -> per-bit history flop d[i] <= data_out[i] (reset RESET_VAL[i]);
//                 rise_pulse = data_out & ~d, fall_pulse = ~data_out & d; exactly
//                 one cycle high in the cycle data_out changes; none after reset.
//    undefined -> no history flops; rise_pulse and fall_pulse tied to 0.
// TESTING
//  1 DWIDTH=4,RESET_VAL=4'b1010,STAGES=2,F=0: hold reset -> data_out=4'b1010;
//    release, data_in=4'b0101 -> data_out=4'b0101 exactly 2 edges after sample.
//  2 STAGES=3,F=4: data_in 0->1 held -> data_out rises on edge 7 (3+4), not 6.
//  3 STAGES=2,F=4: data_in 1-cycle and 3-cycle high glitches -> data_out stays 0,
//    cnt returns to 0; following 4-cycle pulse -> data_out high 1 cycle... held 4.
//  4 F=3, data_out=1, assert rst_n=0 mid-count (cnt=2) -> data_out=RESET_VAL
//    same timestep, cnt=0; after release no spurious transition.
//  5 EDGE_DET_EN on, F=0: data_in 0->1->0 (10 cycles high) -> one rise_pulse and
//    one fall_pulse, each 1 cycle, aligned to data_out edges; none after reset.
//  6 EDGE_DET_EN off: same stimulus as 5 -> rise/fall_pulse constant 0; data_out
//    identical to 5. Randomized async data_in with SVA: data_out changes only
//    after F stable cycles of S; pulses mutually exclusive per bit.

Source files
------------

// File: rtl/c3lib_sync_filt_bitsync.sv
`default_nettype none
// ============================================================================
// Module   : c3lib_sync_filt_bitsync
// Brief    : Multi-bit CDC bit synchronizer with optional per-bit deglitch
//            filter; edge pulses enabled by macro C3LIB_SYNC_EDGE_DET_EN.
// Revision : 1.0 - initial release
// ============================================================================
module c3lib_sync_filt_bitsync #(
    parameter int                DWIDTH      = 1,
    parameter int                SYNC_STAGES = 2,
    parameter logic [DWIDTH-1:0] RESET_VAL   = '0,
    parameter int                FILTER_CNT  = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DWIDTH-1:0] data_in,
    output logic [DWIDTH-1:0] data_out,
    output logic [DWIDTH-1:0] rise_pulse,
    output logic [DWIDTH-1:0] fall_pulse
);

    generate
        if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_stages
            $error("c3lib_sync_filt_bitsync: SYNC_STAGES must be in 2..4");
        end
    endgenerate

    logic [SYNC_STAGES-1:0][DWIDTH-1:0] r_sync;
    logic [DWIDTH-1:0]                  w_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= {SYNC_STAGES{RESET_VAL}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], data_in};
        end
    end

    assign w_sync = r_sync[SYNC_STAGES-1];

    generate
        if (FILTER_CNT == 0) begin : g_no_filt
            assign data_out = w_sync;
        end else begin : g_filt
            localparam int               CNT_W      = (FILTER_CNT < 1) ? 1 : $clog2(FILTER_CNT + 1);
            localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(FILTER_CNT - 1);

            for (genvar i = 0; i < DWIDTH; i++) begin : g_bit
                logic [CNT_W-1:0] r_cnt;
                logic             r_out;

                // Any return of the synced bit to the current output restarts the run.
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        r_cnt <= '0;
                        r_out <= RESET_VAL[i];
                    end else if (w_sync[i] == r_out) begin
                        r_cnt <= '0;
                    end else if (r_cnt == C_CNT_LAST) begin
                        r_out <= w_sync[i];
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                assign data_out[i] = r_out;
            end
        end
    endgenerate

`ifdef C3LIB_SYNC_EDGE_DET_EN
    logic [DWIDTH-1:0] r_hist;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hist <= RESET_VAL;
        end else begin
            r_hist <= data_out;
        end
    end

    assign rise_pulse = data_out & ~r_hist;
    assign fall_pulse = ~data_out & r_hist;
`else
    assign rise_pulse = '0;
    assign fall_pulse = '0;
`endif

endmodule
`default_nettype wire
